single_port_ram_be: RTL and testbench
=====================================

Name: single_port_ram_be

Overview:
Parametrised successor to the 8x64 single-port RAM. Adds a generic width and depth, per-lane byte write enables, and a selectable read latency of 1 or 2 cycles with a q_valid strobe. Also adds a selectable read-during-write mode and an optional post-reset clear sequencer. It is the generic behavioural RAM wrapper used by post-synthesis and post-route netlist benches, and maps to BRAM (TDP18K) in synthesis.

Parameters:
DATA_WIDTH, 8, word width in bits; must be an integer multiple of BYTE_WIDTH, otherwise elaboration fails.
ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH.
BYTE_WIDTH, 8, bits per write lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
READ_LATENCY, 1, 1 = registered memory read; 2 = extra output register. Any other value fails elaboration.
RDW_MODE, 0, read-during-write behaviour: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
CLEAR_ON_RESET, 1, 1 = after reset, write INIT_VALUE to every address before accepting accesses.
INIT_VALUE, 0, DATA_WIDTH-bit fill word used by the clear sequence.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  access enable; no access occurs when 0.
we  input  1  write enable; qualified by en.
be  input  NUM_BYTES  byte-lane write enables; lane i covers data[i*BYTE_WIDTH +: BYTE_WIDTH].
addr  input  ADDR_WIDTH  word address.
data  input  DATA_WIDTH  write data.
q  output  DATA_WIDTH  read data.
q_valid  output  1  one-cycle strobe marking new data on q.
init_busy  output  1  high while the clear sequence runs; accesses are ignored.

Behaviour:
- Reset (rst=1 at an edge):
  - q=0, q_valid=0, pipeline valids cleared.
  - init_busy=1 if CLEAR_ON_RESET, else 0.
  - FSM enters INIT if CLEAR_ON_RESET, else READY.
  - Reset never alters memory contents except through the INIT sequence.
- FSM states: INIT, READY.
  - INIT: an internal counter starts at 0 and writes INIT_VALUE to mem[counter], full word, one address per cycle.
  - After the write to DEPTH-1, go to READY. init_busy falls on the next edge, so it is high for exactly DEPTH cycles after reset deasserts.
  - During INIT, en/we/be/addr/data are ignored and q_valid stays 0.
  - rst mid-INIT restarts the counter at 0.
  - READY persists until rst.
- Read (READY, en=1, we=0):
  - Latency 1: mem[addr] appears on q, with q_valid=1, at edge N+1 for a request sampled at edge N.
  - Latency 2: q and q_valid appear at edge N+2.
  - Back-to-back reads give one result per cycle, in order.
- Write (READY, en=1, we=1):
  - For each lane i with be[i]=1, the lane of mem[addr] takes the data lane; lanes with be[i]=0 are unchanged.
  - be=0 with we=1 writes nothing but is still an access for RDW purposes.
- Read during write (same cycle, same port):
  - WRITE_FIRST: q shows the merged new word (old lanes where be=0), with q_valid=1 at the normal latency.
  - READ_FIRST: q shows the pre-write word, with q_valid=1.
  - NO_CHANGE: q holds its previous value and q_valid=0 for that access.
- Idle (en=0): no memory change; q holds its last value; q_valid=0 at the corresponding latency slot.
- Latency 2 pipeline: stage-1 data and valid register into stage 2 unconditionally each cycle. q updates only when the stage-2 valid is 1, otherwise q holds.
- Address range is exactly DEPTH, so there is no out-of-range case. The counter wraps only via reset.
- Bounds: DEPTH up to 2**16; NUM_BYTES from 1 to 16.

Test Plan:
1. Defaults, CLEAR_ON_RESET=1, INIT_VALUE=8'hA5: release rst, then read all 64 addresses → init_busy high for exactly 64 cycles; every read returns 8'hA5 with q_valid one cycle after each request.
2. Defaults: write $random to addresses 0..63 (en=1, we=1, be=1), then read 0..63 → q matches a scoreboard with 1-cycle latency and q_valid asserted on 64 consecutive cycles.
3. DATA_WIDTH=32, BYTE_WIDTH=8: write 32'h11223344 to addr 5, then be=4'b0101 with data 32'hAABBCCDD, then read addr 5 → q=32'h11BB33DD.
4. DATA_WIDTH=32, mem[7]=32'h0: same-cycle write of 32'hDEADBEEF (be all 1s) to addr 7 under each RDW_MODE → WRITE_FIRST q=32'hDEADBEEF with q_valid=1; READ_FIRST q=32'h0 with q_valid=1; NO_CHANGE q unchanged with q_valid=0. A following read returns 32'hDEADBEEF in all three modes.
5. READ_LATENCY=2: reads to addrs 1, 2, 3 on consecutive cycles with en dropped between 2 and 3 → data at N+2, N+3, N+5; q_valid pattern 1,1,0,1; q holds during the gap.
6. Assert rst at INIT counter=30 for one cycle → init_busy stays high for a further 64 cycles; accesses attempted during INIT leave memory at INIT_VALUE and keep q_valid=0.

Source files
------------

// File: rtl/single_port_ram_be.sv
// Single-port RAM with byte-lane write enables, 1/2-cycle read latency,
// selectable read-during-write mode and an optional post-reset clear pass.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         access enable
//   we         write enable (qualified by en)
//   be         byte-lane write enables, lane i = data[i*BYTE_WIDTH +: BYTE_WIDTH]
//   addr       word address
//   data       write data
//   q          read data, holds between valid results
//   q_valid    one-cycle strobe marking new data on q
//   init_busy  high while the clear pass runs; accesses are ignored then
module single_port_ram_be #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 6,
   parameter int BYTE_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             we,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
   input  logic [ADDR_WIDTH-1:0]            addr,
   input  logic [DATA_WIDTH-1:0]            data,
   output logic [DATA_WIDTH-1:0]            q,
   output logic                             q_valid,
   output logic                             init_busy
);

   localparam int DEPTH     = 2 ** ADDR_WIDTH;
   localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("READ_LATENCY must be 1 or 2");
   end
   if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
      $error("RDW_MODE must be 0, 1 or 2");
   end

   typedef enum logic {
      S_INIT,
      S_READY
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic [DATA_WIDTH-1:0]   old_w;
   logic [DATA_WIDTH-1:0]   merged_w;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    init_wr;
   logic                    access;
   logic                    wr_fire;
   logic                    rd_fire;

   logic                    s1_vld_q, s1_vld_d;
   logic [DATA_WIDTH-1:0]   s1_dat_q, s1_dat_d;

   // Clear pass walks the counter once; the last address ends it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (&cnt_q) begin
            state_d = S_READY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (CLEAR_ON_RESET != 0) ? S_INIT : S_READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign init_busy = (state_q == S_INIT);
   assign init_wr   = (state_q == S_INIT) && !rst;
   assign access    = (state_q == S_READY) && en && !rst;
   assign wr_fire   = access && we;
   // NO_CHANGE suppresses the result of a write access.
   assign rd_fire   = access && (!we || (RDW_MODE != 2));

   assign old_w = mem[addr];

   always_comb begin
      merged_w = old_w;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (be[i]) begin
            merged_w[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   assign rd_word = (we && RDW_MODE == 0) ? merged_w : old_w;

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (init_wr) begin
         mem[cnt_q] <= INIT_VALUE;
      end else if (wr_fire) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) begin
               mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Stage-1 data only moves on a result, so q holds across gaps.
   assign s1_vld_d = rd_fire;
   assign s1_dat_d = rd_fire ? rd_word : s1_dat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_dat_q <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_dat_q <= s1_dat_d;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_vld_q;
      logic [DATA_WIDTH-1:0] s2_dat_q, s2_dat_d;

      assign s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
         end else begin
            s2_vld_q <= s1_vld_q;
            s2_dat_q <= s2_dat_d;
         end
      end

      assign q       = s2_dat_q;
      assign q_valid = s2_vld_q;
   end else begin : g_lat1
      assign q       = s1_dat_q;
      assign q_valid = s1_vld_q;
   end

endmodule

// File: tb/tb_single_port_ram_be.sv
// Bench for single_port_ram_be: four instances (write-first, read-first,
// no-change, latency-2) share one stimulus stream and one reference memory.
module tb_single_port_ram_be;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [5:0]  addr = '0;
   logic [31:0] data = '0;

   logic [31:0] q_o [N];
   logic        qv_o [N];
   logic        ib_o [N];

   always #5 clk = ~clk;

   single_port_ram_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
      .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1),
      .INIT_VALUE(32'hA5A5A5A5)
   ) u_wf (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
      .data(data), .q(q_o[0]), .q_valid(qv_o[0]), .init_busy(ib_o[0])
   );

   single_port_ram_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
      .READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1),
      .INIT_VALUE(32'hA5A5A5A5)
   ) u_rf (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
      .data(data), .q(q_o[1]), .q_valid(qv_o[1]), .init_busy(ib_o[1])
   );

   single_port_ram_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
      .READ_LATENCY(1), .RDW_MODE(2), .CLEAR_ON_RESET(1),
      .INIT_VALUE(32'hA5A5A5A5)
   ) u_nc (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
      .data(data), .q(q_o[2]), .q_valid(qv_o[2]), .init_busy(ib_o[2])
   );

   single_port_ram_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
      .READ_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1),
      .INIT_VALUE(32'hA5A5A5A5)
   ) u_l2 (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
      .data(data), .q(q_o[3]), .q_valid(qv_o[3]), .init_busy(ib_o[3])
   );

   int checks = 0;
   int passes = 0;

   // Reference model state.
   logic [31:0] ref_mem [64];
   int          init_left;
   logic [31:0] exp_q [N];
   logic        exp_v [N];
   logic        dly_v [N];
   logic [31:0] dly_d [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag);
      for (int m = 0; m < N; m++) begin
         chk($sformatf("%s q[%0d]", tag, m), q_o[m], exp_q[m]);
         chk($sformatf("%s qv[%0d]", tag, m), {31'b0, qv_o[m]}, {31'b0, exp_v[m]});
         chk($sformatf("%s busy[%0d]", tag, m), {31'b0, ib_o[m]},
             {31'b0, init_left > 0});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'($urandom);
      we  = 1'($urandom);
      @(posedge clk);
      #1;
      rst = 1'b0;
      init_left = 64;
      for (int m = 0; m < N; m++) begin
         exp_q[m] = '0;
         exp_v[m] = 1'b0;
         dly_v[m] = 1'b0;
         dly_d[m] = '0;
      end
      chk_all("reset");
   endtask

   task automatic step(input logic e, input logic w, input logic [3:0] b,
                       input logic [5:0] a, input logic [31:0] d, input string tag);
      logic        rv [N];
      logic [31:0] rd [N];
      logic [31:0] old, mg;
      en = e; we = w; be = b; addr = a; data = d;
      for (int m = 0; m < N; m++) begin
         rv[m] = 1'b0;
         rd[m] = '0;
      end
      if (init_left > 0) begin
         init_left--;
         if (init_left == 0) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA5A5A5A5;
         end
      end else if (e) begin
         old = ref_mem[a];
         mg  = old;
         for (int i = 0; i < 4; i++) begin
            if (b[i]) mg[i*8 +: 8] = d[i*8 +: 8];
         end
         // write-first, read-first, no-change, latency-2 write-first
         rv[0] = 1'b1; rd[0] = w ? mg : old;
         rv[1] = 1'b1; rd[1] = old;
         rv[2] = !w;   rd[2] = old;
         rv[3] = 1'b1; rd[3] = w ? mg : old;
         if (w) ref_mem[a] = mg;
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < N; m++) begin
         logic        ov;
         logic [31:0] od;
         if (m == 3) begin
            ov = dly_v[m]; od = dly_d[m];
            dly_v[m] = rv[m]; dly_d[m] = rd[m];
         end else begin
            ov = rv[m]; od = rd[m];
         end
         exp_v[m] = ov;
         if (ov) exp_q[m] = od;
      end
      chk_all(tag);
   endtask

   initial begin
      // Clear pass interrupted by reset at counter 30, then a full pass.
      do_reset();
      for (int i = 0; i < 30; i++)
         step(1'($urandom), 1'($urandom), 4'($urandom), 6'($urandom), $urandom, "init_a");
      do_reset();
      for (int i = 0; i < 64; i++)
         step(1'b1, 1'b1, 4'hF, 6'(i), $urandom, "init_b");

      // Every address must hold the fill word.
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 4'h0, 6'(i), $urandom, "fill_rd");
      step(1'b0, 1'b0, 4'h0, 6'd0, '0, "fill_drain");

      // Full-word writes then reads back-to-back.
      for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 4'hF, 6'(i), $urandom, "wr_all");
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 4'h0, 6'(i), '0, "rd_all");
      step(1'b0, 1'b0, 4'h0, 6'd0, '0, "rd_drain");

      // Partial-lane merge.
      step(1'b1, 1'b1, 4'hF, 6'd5, 32'h11223344, "be_full");
      step(1'b1, 1'b1, 4'b0101, 6'd5, 32'hAABBCCDD, "be_part");
      step(1'b1, 1'b0, 4'h0, 6'd5, '0, "be_rd");
      chk("be_merge_const", q_o[0], 32'h11BB33DD);

      // Read-during-write on a zeroed word.
      step(1'b1, 1'b1, 4'hF, 6'd7, 32'h0, "rdw_zero");
      step(1'b0, 1'b0, 4'h0, 6'd0, '0, "rdw_idle");
      step(1'b1, 1'b1, 4'hF, 6'd7, 32'hDEADBEEF, "rdw_wr");
      chk("rdw_wf_const", q_o[0], 32'hDEADBEEF);
      chk("rdw_rf_const", q_o[1], 32'h0);
      chk("rdw_nc_valid", {31'b0, qv_o[2]}, 32'h0);
      step(1'b1, 1'b0, 4'h0, 6'd7, '0, "rdw_rd");
      chk("rdw_nc_rd_const", q_o[2], 32'hDEADBEEF);
      step(1'b0, 1'b0, 4'h0, 6'd0, '0, "rdw_drain");
      chk("rdw_l2_const", q_o[3], 32'hDEADBEEF);

      // Write with no lanes enabled.
      step(1'b1, 1'b1, 4'h0, 6'd7, 32'h12345678, "be_zero");
      step(1'b1, 1'b0, 4'h0, 6'd7, '0, "be_zero_rd");

      // Reads with a gap for the latency-2 pipe.
      step(1'b1, 1'b0, 4'h0, 6'd1, '0, "gap_1");
      step(1'b1, 1'b0, 4'h0, 6'd2, '0, "gap_2");
      step(1'b0, 1'b0, 4'h0, 6'd0, '0, "gap_idle");
      step(1'b1, 1'b0, 4'h0, 6'd3, '0, "gap_3");
      step(1'b0, 1'b0, 4'h0, 6'd0, '0, "gap_d1");
      step(1'b0, 1'b0, 4'h0, 6'd0, '0, "gap_d2");

      // Random traffic over a small address window.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
              6'($urandom_range(0, 7)), $urandom, "rand");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
